mem_port_arb: RTL and testbench
===============================

Name: mem_port_arb

Overview:
- Arbiter and sequencer for the single-port synchronous data/instruction memory of the MPU core.
- Shares the memory between two requesters: instruction fetch (IF) and load/store (LS).
- Drives the memory port, returns read data with valid strobes, and raises a stall to ctrl while a load/store is pending.
- Sits between the core (ctrl, PC, load/store path) and the memory macro; replaces direct mem_sel muxing.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits (byte enables = DATA_W/8)
STARVE_MAX, 3, max consecutive LS grants while IF waits before IF is forced to win

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low
if_req  in  1  fetch request; held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch accepted this cycle (combinational)
if_rvalid  out  1  fetch data valid pulse
if_rdata  out  DATA_W  fetch data
ls_req  in  1  load/store request; held until ls_gnt
ls_we  in  1  1 = store, 0 = load
ls_be  in  DATA_W/8  store byte enables
ls_addr  in  ADDR_W  load/store address
ls_wdata  in  DATA_W  store data
ls_gnt  out  1  load/store accepted this cycle (combinational)
ls_rvalid  out  1  load data valid pulse
ls_rdata  out  DATA_W  load data
mem_addr  out  ADDR_W  memory address (registered)
mem_we  out  1  memory write enable (registered)
mem_be  out  DATA_W/8  memory byte enables (registered)
mem_wdata  out  DATA_W  memory write data (registered)
mem_rdata  in  DATA_W  memory read data, valid one cycle after address
stall  out  1  core stall request

Behaviour:
- Reset (rst = 0 at a clock edge): state IDLE, starvation counter 0, owner 0, and all outputs 0.
- Reset mid-transaction drops the access: no rvalid, and mem_we is 0 on the next cycle.
- States: IDLE, RD, RESP, WR.
- Grants are issued only in IDLE or RESP; at most one gnt per cycle.
- Winner selection:
  - LS wins over IF, unless the starvation counter == STARVE_MAX; then IF wins.
  - The counter increments on each ls_gnt while if_req = 1.
  - It clears on if_gnt or when if_req = 0.
  - It saturates at STARVE_MAX.
- On a grant, mem_addr <= {addr[ADDR_W-1:2], 2'b00}; owner is recorded.
- Load or fetch: mem_we <= 0, mem_be <= all ones; next state RD.
- Store: mem_we <= 1, mem_be <= ls_be, mem_wdata <= ls_wdata; next state WR.
- RD: memory samples the address; next state RESP unconditionally.
- RESP:
  - The owner's rvalid = 1; rdata = mem_rdata (combinational passthrough).
  - A new grant is allowed in the same cycle (back-to-back); otherwise next state IDLE.
- WR: mem_we = 1 for exactly one cycle. Next state IDLE, where mem_we <= 0 and mem_be <= 0. No grant in WR.
- Latency:
  - Read: gnt in cycle N, rvalid in N+2.
  - Write: gnt in N, mem_we high in N+1.
  - Peak throughput: one access per 2 cycles.
- Inactive outputs: rvalid of the non-owner is 0, and its rdata is 0. mem_addr and mem_wdata hold their last values when idle.
- stall = (ls_req & ~ls_gnt) | (LS owns an access in RD, or in RESP before ls_rvalid).
- Boundary rules:
  - A request dropped before gnt is legal and has no effect.
  - Request inputs are ignored except in the grant cycle.
  - Simultaneous if_req and ls_req in RESP follow the same priority rule.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: the starvation counter and STARVE_MAX are unused. On simultaneous requests, the winner is the requester not granted last; the last-granted flag resets to IF, so LS wins the first contention.
- Undefined: LS-priority with starvation limit, as above.

Test Plan:
- Reset: hold rst = 0 for 2 cycles with both reqs high -> all outputs 0, no gnt; release -> ls_gnt in the first active cycle.
- Single fetch: if_req = 1, if_addr = 0x0000_0106, memory word 0x00A0_0093 -> if_gnt at N, mem_addr = 0x0000_0104 at N+1, if_rvalid = 1 with if_rdata = 0x00A0_0093 at N+2, ls_rvalid = 0.
- Store: ls_we = 1, ls_be = 4'b0011, ls_addr = 0x40, ls_wdata = 0x1234_5678 -> mem_we = 1 and mem_be = 0011 for exactly one cycle at N+1, then 0; stall = 1 only while ls_req is high and ungranted.
- Starvation (default build): if_req and ls_req held high, loads only -> grant sequence LS, LS, LS, IF, LS, ...; back-to-back grants every 2 cycles.
- Round-robin (MEM_ARB_ROUND_ROBIN_EN): both reqs held high -> grants alternate LS, IF, LS, IF.
- Reset mid-read: rst = 0 in the RD cycle of an LS load -> no ls_rvalid, state IDLE, stall = 0 after the reset edge.

Source files
------------

// File: rtl/mem_port_arb.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arb
// Description : Arbiter/sequencer for the single-port synchronous memory of
//               the MPU core. Shares the port between instruction fetch (IF)
//               and load/store (LS), drives registered memory controls,
//               returns read data with valid strobes and stalls the core
//               while a load/store is pending.
//               Optional macro MEM_ARB_ROUND_ROBIN_EN replaces LS-priority
//               with starvation limit by round-robin arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arb #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [DATA_W/8-1:0]   ls_be,
    input  logic [ADDR_W-1:0]     ls_addr,
    input  logic [DATA_W-1:0]     ls_wdata,
    output logic                  ls_gnt,
    output logic                  ls_rvalid,
    output logic [DATA_W-1:0]     ls_rdata,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  stall
);

    localparam int c_BE_W = DATA_W / 8;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RD   = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;
    localparam logic [1:0] c_WR   = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_owner_ls;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [c_BE_W-1:0] r_mem_be;
    logic [DATA_W-1:0] r_mem_wdata;

    logic w_grant_ok;
    logic w_ls_wins;
    logic w_if_gnt;
    logic w_ls_gnt;
    logic w_resp;

    // Word alignment drops the two byte-offset bits of both address inputs.
    logic w_unused;
    assign w_unused = ^{if_addr[1:0], ls_addr[1:0]};

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic r_last_ls;

    // Requester not granted last wins contention; starts at IF so LS wins first.
    always_comb begin
        w_ls_wins = ls_req & (~if_req | ~r_last_ls);
    end

    // Remember which requester received the most recent grant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_ls <= 1'b0;
        end else if (w_ls_gnt) begin
            r_last_ls <= 1'b1;
        end else if (w_if_gnt) begin
            r_last_ls <= 1'b0;
        end
    end
`else
    localparam int             c_CNT_W      = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_MAX);

    logic [c_CNT_W-1:0] r_starve;

    // LS has priority unless IF has already waited through STARVE_MAX LS grants.
    always_comb begin
        w_ls_wins = ls_req & (~if_req | (r_starve != c_STARVE_MAX));
    end

    // Count consecutive LS grants while IF waits; clear when IF is served or idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_starve <= '0;
        end else if (w_if_gnt || !if_req) begin
            r_starve <= '0;
        end else if (w_ls_gnt && (r_starve != c_STARVE_MAX)) begin
            r_starve <= r_starve + 1'b1;
        end
    end
`endif

    // Grants only from IDLE or RESP, one winner at most, never during reset.
    always_comb begin
        w_grant_ok = rst & ((r_state == c_IDLE) | (r_state == c_RESP));
        w_ls_gnt   = w_grant_ok & w_ls_wins;
        w_if_gnt   = w_grant_ok & if_req & ~w_ls_wins;
    end

    // Next-state selection for the access sequencer.
    always_comb begin
        w_state_nxt = c_IDLE;
        case (r_state)
            c_IDLE, c_RESP: begin
                if (w_ls_gnt) begin
                    w_state_nxt = ls_we ? c_WR : c_RD;
                end else if (w_if_gnt) begin
                    w_state_nxt = c_RD;
                end else begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_RD:    w_state_nxt = c_RESP;
            c_WR:    w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Launch the granted access on the memory port and record its owner.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_owner_ls  <= 1'b0;
        end else if (w_ls_gnt) begin
            r_mem_addr <= {ls_addr[ADDR_W-1:2], 2'b00};
            r_mem_we   <= ls_we;
            r_mem_be   <= ls_we ? ls_be : {c_BE_W{1'b1}};
            if (ls_we) begin
                r_mem_wdata <= ls_wdata;
            end
            r_owner_ls <= 1'b1;
        end else if (w_if_gnt) begin
            r_mem_addr <= {if_addr[ADDR_W-1:2], 2'b00};
            r_mem_we   <= 1'b0;
            r_mem_be   <= {c_BE_W{1'b1}};
            r_owner_ls <= 1'b0;
        end else if (r_state == c_WR) begin
            // Write strobe lasts exactly one cycle.
            r_mem_we <= 1'b0;
            r_mem_be <= '0;
        end
    end

    // Response steering and stall generation.
    always_comb begin
        w_resp    = rst & (r_state == c_RESP);
        if_gnt    = w_if_gnt;
        ls_gnt    = w_ls_gnt;
        if_rvalid = w_resp & ~r_owner_ls;
        ls_rvalid = w_resp & r_owner_ls;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        ls_rdata  = ls_rvalid ? mem_rdata : '0;
        stall     = rst & ((ls_req & ~w_ls_gnt) |
                           (r_owner_ls & ((r_state == c_RD) |
                                          ((r_state == c_RESP) & ~ls_rvalid))));
    end

    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arb
// Description : Scoreboard bench for mem_port_arb with a behavioural memory,
//               an access-level reference model and randomized requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arb;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int BE_W       = DATA_W / 8;
    localparam int STARVE_MAX = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              ls_req;
    logic              ls_we;
    logic [BE_W-1:0]   ls_be;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall;

    mem_port_arb #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_be     (ls_be),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int errors = 0;
    int cycle  = 0;
    logic rst_q = 1'b0;

    always @(posedge clk) begin
        cycle <= cycle + 1;
        rst_q <= rst;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cycle, act, exp);
        end
    endtask

    // Memory macro: one-cycle read latency, byte-enabled write.
    logic [DATA_W-1:0] macro_mem [0:255];
    logic [DATA_W-1:0] ref_mem   [0:255];

    always @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (mem_be[b]) macro_mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        mem_rdata <= macro_mem[mem_addr[9:2]];
    end

    // ---------------- reference model (access level) ----------------
    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t if_q[$];
    exp_t ls_q[$];

    int                last_gnt    = -10;
    int                streak      = 0;
    bit                rr_last_ls  = 1'b0;
    int                ls_read_cyc = -10;
    bit                pv          = 1'b0;
    int                pcyc        = 0;
    logic [ADDR_W-1:0] paddr;
    bit                pwe;
    logic [BE_W-1:0]   pbe;
    logic [DATA_W-1:0] pwd;

    always @(negedge clk) begin
        bit e_if, e_ls, ok, lsw, e_stall;
        int idx;
        if (!rst) begin
            chk("if_gnt_rst", if_gnt, 0);
            chk("ls_gnt_rst", ls_gnt, 0);
            chk("stall_rst", stall, 0);
            chk("rvalid_rst", {if_rvalid, ls_rvalid}, 0);
            if (!rst_q) chk("mem_regs_rst", {mem_addr, mem_we, mem_be, mem_wdata}, 0);
            last_gnt = -10; streak = 0; rr_last_ls = 1'b0; ls_read_cyc = -10; pv = 1'b0;
            if_q.delete();
            ls_q.delete();
        end else begin
            // Any new access needs two cycles after the previous one was granted.
            ok = (cycle - last_gnt) >= 2;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            lsw = !if_req || !rr_last_ls;
`else
            lsw = !if_req || (streak != STARVE_MAX);
`endif
            e_ls = ok && ls_req && lsw;
            e_if = ok && if_req && !e_ls;
            chk("if_gnt", if_gnt, e_if);
            chk("ls_gnt", ls_gnt, e_ls);
            e_stall = (ls_req && !e_ls) || (ls_read_cyc == cycle - 1);
            chk("stall", stall, e_stall);

            if (!rst_q) begin
                chk("mem_regs_after_rst", {mem_addr, mem_we, mem_be, mem_wdata}, 0);
            end else if (pv && cycle == pcyc + 1) begin
                chk("mem_addr", mem_addr, paddr);
                chk("mem_we", mem_we, pwe);
                chk("mem_be", mem_be, pbe);
                if (pwe) chk("mem_wdata", mem_wdata, pwd);
            end else begin
                chk("mem_we_idle", mem_we, 0);
            end

            if (e_ls) begin
                last_gnt = cycle; rr_last_ls = 1'b1;
                idx = int'(ls_addr[9:2]);
                pv = 1'b1; pcyc = cycle; paddr = {ls_addr[ADDR_W-1:2], 2'b00};
                pwe = ls_we; pbe = ls_we ? ls_be : '1; pwd = ls_wdata;
                if (ls_we) begin
                    for (int b = 0; b < BE_W; b++)
                        if (ls_be[b]) ref_mem[idx][8*b +: 8] = ls_wdata[8*b +: 8];
                end else begin
                    ls_q.push_back('{cycle + 2, ref_mem[idx]});
                    ls_read_cyc = cycle;
                end
            end
            if (e_if) begin
                last_gnt = cycle; rr_last_ls = 1'b0;
                idx = int'(if_addr[9:2]);
                pv = 1'b1; pcyc = cycle; paddr = {if_addr[ADDR_W-1:2], 2'b00};
                pwe = 1'b0; pbe = '1; pwd = '0;
                if_q.push_back('{cycle + 2, ref_mem[idx]});
            end
            if (!if_req || e_if) streak = 0;
            else if (e_ls && streak < STARVE_MAX) streak++;
        end
    end

    // ---------------- monitor: pops scoreboard on response cycles ----------------
    always @(negedge clk) begin
        if (rst) begin
            if (if_q.size() > 0 && if_q[0].due == cycle) begin
                chk("if_rvalid", if_rvalid, 1);
                chk("if_rdata", if_rdata, if_q[0].data);
                void'(if_q.pop_front());
            end else begin
                chk("if_rvalid_idle", if_rvalid, 0);
                chk("if_rdata_idle", if_rdata, 0);
            end
            if (ls_q.size() > 0 && ls_q[0].due == cycle) begin
                chk("ls_rvalid", ls_rvalid, 1);
                chk("ls_rdata", ls_rdata, ls_q[0].data);
                void'(ls_q.pop_front());
            end else begin
                chk("ls_rvalid_idle", ls_rvalid, 0);
                chk("ls_rdata_idle", ls_rdata, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    bit gi, gl;

    task automatic step();
        @(negedge clk);
        gi = if_gnt;
        gl = ls_gnt;
        @(posedge clk);
        #1;
    endtask

    task automatic do_if(input logic [ADDR_W-1:0] a);
        bit got = 1'b0;
        if_req = 1'b1; if_addr = a;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            if (gi) got = 1'b1;
        end
        if_req = 1'b0;
        chk("if_gnt_timeout", got, 1);
    endtask

    task automatic do_ls(input bit we, input logic [BE_W-1:0] be,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
        bit got = 1'b0;
        ls_req = 1'b1; ls_we = we; ls_be = be; ls_addr = a; ls_wdata = wd;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            if (gl) got = 1'b1;
        end
        ls_req = 1'b0;
        chk("ls_gnt_timeout", got, 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [DATA_W-1:0] v;
            v = $urandom;
            macro_mem[i] = v;
            ref_mem[i]   = v;
        end
        macro_mem[65] = 32'h00A0_0093;
        ref_mem[65]   = 32'h00A0_0093;

        // Reset held with both requesters active.
        rst = 1'b0; if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; ls_be = '0;
        if_addr = 32'h10; ls_addr = 32'h20; ls_wdata = '0;
        step();
        step();
        rst = 1'b1;
        step();
        if_req = 1'b0; ls_req = 1'b0;
        repeat (4) step();

        // Directed fetch, store, and load-back of the stored word.
        do_if(32'h0000_0106);
        repeat (3) step();
        do_ls(1'b1, 4'b0011, 32'h40, 32'h1234_5678);
        repeat (3) step();
        do_ls(1'b0, 4'b0000, 32'h40, 32'h0);
        repeat (3) step();

        // Contention with loads only: starvation limit shapes the grant sequence.
        if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (gi) if_addr = $urandom_range(0, 1023);
            if (gl) ls_addr = $urandom_range(0, 1023);
        end
        if_req = 1'b0; ls_req = 1'b0;
        repeat (3) step();

        // Randomized traffic with occasional dropped requests.
        for (int k = 0; k < 800; k++) begin
            step();
            if (gi) if_req = 1'b0;
            if (gl) ls_req = 1'b0;
            if (!if_req && ($urandom % 2 == 0)) begin
                if_req = 1'b1; if_addr = $urandom_range(0, 1023);
            end else if (if_req && !gi && ($urandom % 16 == 0)) begin
                if_req = 1'b0;
            end
            if (!ls_req && ($urandom % 2 == 0)) begin
                ls_req = 1'b1; ls_we = $urandom % 2; ls_be = $urandom;
                ls_addr = $urandom_range(0, 1023); ls_wdata = $urandom;
            end else if (ls_req && !gl && ($urandom % 16 == 0)) begin
                ls_req = 1'b0;
            end
        end
        if_req = 1'b0; ls_req = 1'b0;
        repeat (4) step();

        // Reset during the RD cycle of a load drops the access.
        do_ls(1'b0, 4'b0000, 32'h80, 32'h0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        repeat (4) step();

        chk("scoreboard_drained", if_q.size() + ls_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
`default_nettype wire
